feature_weight_transform: RTL and testbench
===========================================

# feature_weight_transform

Transformation stage of the GCN datapath: fetches the weight columns and feature rows from the shared input memory, computes the FM×WM product one dot product per cycle, and stores the FEATURE_ROWS × WEIGHT_COLS result in an internal row buffer. It sits directly upstream of the combination (adjacency aggregation) stage, which reads product rows through `read_row` / `fm_wm_row_data` once `done` is high.

## Interface
- FEATURE_COLS, 96: elements per feature row.
- WEIGHT_ROWS, 96: elements per weight column; must equal FEATURE_COLS.
- FEATURE_ROWS, 6: number of feature rows (graph nodes).
- WEIGHT_COLS, 3: number of weight columns.
- FEATURE_WIDTH, 5: unsigned feature element width.
- WEIGHT_WIDTH, 5: unsigned weight element width; must equal FEATURE_WIDTH.
- DOT_PROD_WIDTH, 16: result element width.
- ADDRESS_WIDTH, 13: input memory address width.
- FEATURE_BASE_ADDR, 13'h200: address of feature row 0.
- ROW_BW, $clog2(FEATURE_ROWS): row index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a transform; sampled in IDLE only.
- data_in  in  [WEIGHT_WIDTH-1:0] x [0:WEIGHT_ROWS-1]  input memory read data; valid one cycle after the request.
- read_row  in  ROW_BW  product row selected by the downstream stage.
- read_address  out  ADDRESS_WIDTH  input memory address.
- enable_read  out  1  input memory read strobe.
- fm_wm_row_data  out  [DOT_PROD_WIDTH-1:0] x [0:WEIGHT_COLS-1]  product row `read_row`; combinational read.
- done  out  1  all product rows written.

## Operation
- States: IDLE, REQ_W, CAP_W, REQ_F, CAP_F, MAC, WRITE, DONE.
- IDLE → REQ_W on start; col counter cleared to 0.
- REQ_W: enable_read=1, read_address=col counter. Next state is CAP_W.
- CAP_W: latch data_in into weight register [col]. If col==WEIGHT_COLS-1, clear col and row, then go to REQ_F. Otherwise increment col and return to REQ_W.
- REQ_F: enable_read=1, read_address=FEATURE_BASE_ADDR+row. Next state is CAP_F.
- CAP_F: latch data_in into the feature register. Next state is MAC with col=0.
- MAC: compute the dot product of the feature register and weight[col] and latch it into staging element [col]. If col==WEIGHT_COLS-1, go to WRITE; otherwise increment col.
- WRITE: copy the staging row into row buffer [row]. If row==FEATURE_ROWS-1, go to DONE. Otherwise increment row and go to REQ_F.
- DONE: done=1. The state is sticky until reset; start is ignored.
- Outside REQ states: enable_read=0 and read_address=0.
- Arithmetic is unsigned. Each product is 2×WIDTH bits, and the sum is accumulated at full width (17 bits at the defaults). The lower DOT_PROD_WIDTH bits are stored, so overflow wraps with no saturation.
- fm_wm_row_data = buffer[read_row] at all times, including before done, when partially written rows are visible.
- If read_row ≥ FEATURE_ROWS, fm_wm_row_data is all zeros.
- start in any state other than IDLE is ignored.

## Timing
- Reset values: state=IDLE, done=0, enable_read=0, read_address=0, counters=0, all weight, feature, staging and row buffer entries=0. With reset values, fm_wm_row_data=0.
- Reset asserted mid-operation: on the next edge all state and the buffer are cleared, and any in-flight memory data is discarded.
- Memory read latency is 1 cycle: the request is presented in a REQ cycle and data_in is sampled in the following CAP cycle.
- Weight load takes 2×WEIGHT_COLS = 6 cycles.
- Each feature row takes 2 + WEIGHT_COLS + 1 = 6 cycles; all rows take 36.
- Latency: with start sampled in cycle 0, done is first high in cycle 43 and stays high.
- Row r becomes readable in the cycle after its WRITE, i.e. cycle 13+6r.
- Address sequence at the defaults: 0, 1, 2, then 0x200 … 0x205, each for one enable_read cycle.

## Test plan
- All data_in elements = 1 and start pulsed → read_address sequence 0, 1, 2, 0x200 … 0x205 with enable_read high for exactly 9 cycles; done rises in cycle 43; every fm_wm_row_data element = 96.
- All elements = 31 → every element = 92256 mod 65536 = 26720, confirming wrap without saturation.
- Weight columns are unit vectors e0, e1, e2, and feature row r element k = (r+k) mod 32 → row r reads {r, r+1, r+2}. Sweep read_row 0..5 after done.
- Assert reset in cycle 20, then restart → at cycle 21 done=0, enable_read=0 and all rows read 0; the second run completes 43 cycles after its start with correct data.
- read_row=6 and read_row=7 after done → fm_wm_row_data all zeros. start pulsed in DONE and mid-MAC → no effect on the state sequence or done timing.
- Poll read_row=0 from cycle 0 → zeros until cycle 13, correct product from cycle 13 onward.

Source files
------------

// File: rtl/feature_weight_transform.sv
// feature_weight_transform: GCN transform stage computing FM x WM into a readable row buffer
module feature_weight_transform #(
  parameter int FEATURE_COLS = 96,
  parameter int WEIGHT_ROWS = 96,
  parameter int FEATURE_ROWS = 6,
  parameter int WEIGHT_COLS = 3,
  parameter int FEATURE_WIDTH = 5,
  parameter int WEIGHT_WIDTH = 5,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ADDRESS_WIDTH = 13,
  parameter logic [ADDRESS_WIDTH-1:0] FEATURE_BASE_ADDR = 13'h200,
  parameter int ROW_BW = $clog2(FEATURE_ROWS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [WEIGHT_WIDTH-1:0]   data_in [0:WEIGHT_ROWS-1],
  input  logic [ROW_BW-1:0]         read_row,
  output logic [ADDRESS_WIDTH-1:0]  read_address,
  output logic                      enable_read,
  output logic [DOT_PROD_WIDTH-1:0] fm_wm_row_data [0:WEIGHT_COLS-1],
  output logic                      done
);
  localparam int COL_BW = WEIGHT_COLS > 1 ? $clog2(WEIGHT_COLS) : 1;
  localparam int PROD_W = FEATURE_WIDTH + WEIGHT_WIDTH;
  localparam int ACC_W = PROD_W + $clog2(FEATURE_COLS);
  typedef enum logic [2:0] {IDLE, REQ_W, CAP_W, REQ_F, CAP_F, MAC, WRITE, DONE} state_t;
  state_t state, next_state;
  logic [COL_BW-1:0] col;
  logic [ROW_BW-1:0] row;
  logic [WEIGHT_WIDTH-1:0] weight [0:WEIGHT_COLS-1][0:WEIGHT_ROWS-1];
  logic [FEATURE_WIDTH-1:0] feature [0:FEATURE_COLS-1];
  logic [DOT_PROD_WIDTH-1:0] staging [0:WEIGHT_COLS-1];
  logic [DOT_PROD_WIDTH-1:0] row_buf [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];
  logic [ACC_W-1:0] acc;
  logic last_col, last_row;
  assign last_col = col == COL_BW'(WEIGHT_COLS - 1);
  assign last_row = row == ROW_BW'(FEATURE_ROWS - 1);
  assign done = state == DONE;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : next_state;
  // next state and memory request strobes; address is zero outside request cycles
  always_comb begin
    next_state = state;
    enable_read = 1'b0;
    read_address = '0;
    case (state)
      IDLE:  next_state = start ? REQ_W : IDLE;
      REQ_W: begin
        enable_read = 1'b1;
        read_address = ADDRESS_WIDTH'(col);
        next_state = CAP_W;
      end
      CAP_W: next_state = last_col ? REQ_F : REQ_W;
      REQ_F: begin
        enable_read = 1'b1;
        read_address = FEATURE_BASE_ADDR + ADDRESS_WIDTH'(row);
        next_state = CAP_F;
      end
      CAP_F: next_state = MAC;
      MAC:   next_state = last_col ? WRITE : MAC;
      WRITE: next_state = last_row ? DONE : REQ_F;
      DONE:  next_state = DONE;
      default: next_state = IDLE;
    endcase
  end
  // full-width unsigned dot product of the feature row with the current weight column
  always_comb begin
    acc = '0;
    for (int k = 0; k < FEATURE_COLS; k++)
      acc = acc + ACC_W'(PROD_W'(feature[k]) * PROD_W'(weight[col][k]));
  end
  // counters, operand capture, staging and row buffer writes
  always_ff @(posedge clk)
    if (reset) begin
      col <= '0;
      row <= '0;
      weight <= '{default: '0};
      feature <= '{default: '0};
      staging <= '{default: '0};
      row_buf <= '{default: '0};
    end else begin
      case (state)
        IDLE:  if (start) col <= '0;
        CAP_W: begin
          weight[col] <= data_in;
          col <= last_col ? '0 : col + 1'b1;
          if (last_col) row <= '0;
        end
        CAP_F: begin
          feature <= data_in;
          col <= '0;
        end
        MAC: begin
          staging[col] <= acc[DOT_PROD_WIDTH-1:0];
          if (!last_col) col <= col + 1'b1;
        end
        WRITE: begin
          row_buf[row] <= staging;
          if (!last_row) row <= row + 1'b1;
        end
        default: ;
      endcase
    end
  // combinational product row read; rows beyond the buffer read as zero
  always_comb
    for (int c = 0; c < WEIGHT_COLS; c++)
      fm_wm_row_data[c] = ({1'b0, read_row} < (ROW_BW + 1)'(FEATURE_ROWS)) ? row_buf[read_row][c] : '0;
endmodule

// File: tb/tb_feature_weight_transform.sv
`timescale 1ns/1ps
// tb_feature_weight_transform: directed checks of the GCN transform stage
module tb_feature_weight_transform;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [4:0] data_in [0:95];
  logic [2:0] read_row = 3'd0;
  logic [12:0] read_address;
  logic enable_read, done;
  logic [15:0] fm_wm_row_data [0:2];
  logic [4:0] wmem [0:2][0:95];
  logic [4:0] fmem [0:5][0:95];
  int checks = 0;
  int passed = 0;

  feature_weight_transform dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .read_row(read_row),
    .read_address(read_address), .enable_read(enable_read),
    .fm_wm_row_data(fm_wm_row_data), .done(done)
  );

  always #10 clk = ~clk;

  // memory model: request seen in a REQ cycle, data held stable through the CAP cycle
  always @(negedge clk)
    if (enable_read)
      for (int k = 0; k < 96; k++)
        data_in[k] = (read_address < 13'd3) ? wmem[read_address[1:0]][k] :
                     (read_address >= 13'h200 && read_address < 13'h206) ? fmem[read_address - 13'h200][k] : 5'd0;

  task automatic fill_const(input logic [4:0] v);
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 96; k++) begin
        fmem[r][k] = v;
        if (r < 3) wmem[r][k] = v;
      end
  endtask

  task automatic fill_unit();
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 96; k++) begin
        fmem[r][k] = 5'((r + k) % 32);
        if (r < 3) wmem[r][k] = (k == r) ? 5'd1 : 5'd0;
      end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_to_done(output int lat);
    pulse_start();
    lat = -1;
    for (int n = 1; n <= 80 && lat < 0; n++) begin
      @(negedge clk);
      if (done) lat = n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (enable_read !== 1'b0) $display("FAIL reset_en got %b want 0", enable_read); else passed++;
    checks++; if (read_address !== 13'd0) $display("FAIL reset_addr got %h want 0", read_address); else passed++;
    for (int r = 0; r < 6; r++) begin
      read_row = 3'(r);
      #1;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (fm_wm_row_data[c] !== 16'd0) $display("FAIL reset_row r=%0d c=%0d got %0d want 0", r, c, fm_wm_row_data[c]); else passed++;
      end
    end
    read_row = 3'd0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_ones_trace();
    int req_cyc [9] = '{1, 3, 5, 7, 13, 19, 25, 31, 37};
    logic [12:0] req_adr [9] = '{13'h0, 13'h1, 13'h2, 13'h200, 13'h201, 13'h202, 13'h203, 13'h204, 13'h205};
    int idx = 0;
    logic exp_en;
    logic [15:0] exp;
    fill_const(5'd1);
    do_reset();
    read_row = 3'd0;
    pulse_start();
    for (int n = 1; n <= 46; n++) begin
      @(negedge clk);
      exp_en = (idx < 9) && (n == req_cyc[idx]);
      checks++;
      if (enable_read !== exp_en) $display("FAIL trace_en cycle %0d got %b want %b", n, enable_read, exp_en); else passed++;
      if (exp_en) begin
        checks++;
        if (read_address !== req_adr[idx]) $display("FAIL trace_addr cycle %0d got %h want %h", n, read_address, req_adr[idx]); else passed++;
        idx++;
      end
      checks++;
      if (done !== (n >= 43)) $display("FAIL trace_done cycle %0d got %b want %b", n, done, n >= 43); else passed++;
      exp = (n >= 13) ? 16'd96 : 16'd0;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (fm_wm_row_data[c] !== exp) $display("FAIL poll_row0 cycle %0d c=%0d got %0d want %0d", n, c, fm_wm_row_data[c], exp); else passed++;
      end
      start = (n == 9);
    end
    checks++;
    if (idx !== 9) $display("FAIL trace_req_count got %0d want 9", idx); else passed++;
    for (int r = 0; r < 6; r++) begin
      read_row = 3'(r);
      #1;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (fm_wm_row_data[c] !== 16'd96) $display("FAIL ones_row r=%0d c=%0d got %0d want 96", r, c, fm_wm_row_data[c]); else passed++;
      end
    end
    read_row = 3'd0;
  endtask

  task automatic test_wrap();
    int lat;
    fill_const(5'd31);
    do_reset();
    run_to_done(lat);
    checks++;
    if (lat !== 43) $display("FAIL wrap_latency got %0d want 43", lat); else passed++;
    for (int r = 0; r < 6; r++) begin
      read_row = 3'(r);
      #1;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (fm_wm_row_data[c] !== 16'd26720) $display("FAIL wrap_row r=%0d c=%0d got %0d want 26720", r, c, fm_wm_row_data[c]); else passed++;
      end
    end
    read_row = 3'd0;
  endtask

  task automatic test_unit_and_range();
    int lat;
    logic [15:0] exp;
    fill_unit();
    do_reset();
    run_to_done(lat);
    checks++;
    if (lat !== 43) $display("FAIL unit_latency got %0d want 43", lat); else passed++;
    for (int r = 0; r < 8; r++) begin
      read_row = 3'(r);
      #1;
      for (int c = 0; c < 3; c++) begin
        exp = (r < 6) ? 16'(r + c) : 16'd0;
        checks++;
        if (fm_wm_row_data[c] !== exp) $display("FAIL unit_row r=%0d c=%0d got %0d want %0d", r, c, fm_wm_row_data[c], exp); else passed++;
      end
    end
    read_row = 3'd0;
    pulse_start();
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b1) $display("FAIL done_sticky step %0d got %b want 1", n, done); else passed++;
      checks++;
      if (enable_read !== 1'b0) $display("FAIL done_no_read step %0d got %b want 0", n, enable_read); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [15:0] exp;
    fill_const(5'd1);
    do_reset();
    read_row = 3'd0;
    pulse_start();
    for (int n = 1; n <= 20; n++) @(negedge clk);
    checks++;
    if (fm_wm_row_data[0] !== 16'd96) $display("FAIL mid_pre_row0 got %0d want 96", fm_wm_row_data[0]); else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL mid_done got %b want 0", done); else passed++;
    checks++; if (enable_read !== 1'b0) $display("FAIL mid_en got %b want 0", enable_read); else passed++;
    for (int r = 0; r < 6; r++) begin
      read_row = 3'(r);
      #1;
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (fm_wm_row_data[c] !== 16'd0) $display("FAIL mid_cleared r=%0d c=%0d got %0d want 0", r, c, fm_wm_row_data[c]); else passed++;
      end
    end
    read_row = 3'd0;
    reset = 1'b0;
    fill_unit();
    run_to_done(lat);
    checks++;
    if (lat !== 43) $display("FAIL mid_rerun_latency got %0d want 43", lat); else passed++;
    for (int r = 0; r < 6; r++) begin
      read_row = 3'(r);
      #1;
      for (int c = 0; c < 3; c++) begin
        exp = 16'(r + c);
        checks++;
        if (fm_wm_row_data[c] !== exp) $display("FAIL mid_rerun_row r=%0d c=%0d got %0d want %0d", r, c, fm_wm_row_data[c], exp); else passed++;
      end
    end
    read_row = 3'd0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 96; k++) data_in[k] = 5'd0;
    fill_const(5'd0);
    test_reset();
    test_ones_trace();
    test_wrap();
    test_unit_and_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
